if_stage: RTL and testbench
===========================

IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-002 Parameter EXC_PC, default 32'h0000_0180: documented exception vector; exc_vector is the port actually used for redirects.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 clr  in  1  reset, synchronous, active-high.
REQ-005 stall  in  1  ID not accepting; hold IF/ID outputs.
REQ-006 br_taken  in  1 / br_target  in  32  branch/jump redirect from ID.
REQ-007 exc_redirect  in  1 / exc_vector  in  32  exception redirect.
REQ-008 imem_req  out  1 / imem_addr  out  32  instruction-memory request and word address.
REQ-009 imem_ready  in  1 / imem_rdata  in  32  completion; rdata valid only in the ready cycle.
REQ-010 if_id_valid  out  1 / if_id_pc  out  32 / if_id_pc4  out  32 / if_id_instr  out  32  IF/ID pipeline register.

Function
REQ-011 States: BOOT, FETCH, KILL, HELD; no other encodings reachable.
REQ-012 BOOT: imem_req=0; next cycle go to FETCH with pc=RESET_PC.
REQ-013 FETCH: imem_req=1, imem_addr=pc; once asserted, req and addr stay constant until imem_ready=1.
REQ-014 FETCH, ready=1, stall=0, no redirect: IF/ID loads {valid=1, pc, pc+4, rdata}; pc<=pc+4; stay in FETCH; throughput one instruction per ready cycle.
REQ-015 FETCH, ready=1, stall=1: rdata and pc go into a one-entry hold buffer; go to HELD; imem_req=0 while in HELD.
REQ-016 HELD, stall=0: buffer moves into IF/ID; pc<=pc+4; go to FETCH.
REQ-017 Redirect target: exc_redirect has priority over br_taken; exc_vector is used when both are asserted.
REQ-018 Any redirect in any state: if_id_valid<=0 next cycle; the hold buffer is invalidated; stall is overridden.
REQ-019 Redirect in FETCH with ready=1, or in HELD: pc<=target; next state FETCH.
REQ-020 Redirect in FETCH with ready=0: the target is latched into pend_pc; go to KILL.
REQ-021 KILL: req/addr hold the old values until ready; the returned word is discarded; then pc<=pend_pc and go to FETCH.
REQ-022 A second redirect during KILL overwrites pend_pc; the latest target wins.
REQ-023 stall=1 with no redirect: all IF/ID outputs hold their values.
REQ-024 PC arithmetic is 32-bit modulo; 32'hFFFF_FFFC+4 wraps to 0.
REQ-025 Targets are used as given; alignment is not checked here.

Reset
REQ-026 With clr=1 at a rising edge, the next state is: state=BOOT, pc=RESET_PC, pend_pc=0, hold buffer empty, if_id_valid=0, if_id_pc/pc4/instr=0, imem_req=0.
REQ-027 clr overrides every input, including an outstanding request.
REQ-028 The memory model must tolerate a request being abandoned by clr.

Structure
REQ-029 A shared CPU package holds the state encodings, RESET_PC, EXC_PC, and the 32-bit word/address width constant.
REQ-030 The IF/ID register is one sub-module, if_id_reg, with enable, sync flush and sync clear; if_stage contains the FSM, pc, pend_pc and the hold buffer.

Verification
REQ-031 Sequential fetch: clr for 2 cycles, memory always ready -> addr 0,4,8,12; if_id_pc follows one cycle later, if_id_pc4 = pc+4.
REQ-032 Stall in HELD: stall=1 when word 0x8 returns -> HELD, imem_req=0, if_id unchanged; stall=0 -> if_id_instr is the word from 0x8 and the next addr is 0xC.
REQ-033 Branch in KILL: br_taken, target 0x100, during a 3-cycle wait at 0x10 -> addr stays 0x10 until ready, if_id_valid=0, the word is discarded, the next addr is 0x100.
REQ-034 Simultaneous redirects: exc_redirect (exc_vector 0x180) and br_taken (target 0x200) in the same cycle -> next addr 0x180.
REQ-035 Wrap-around: redirect to 0xFFFF_FFFC -> the following addr is 0x0000_0000.
REQ-036 Reset mid-fetch: clr while req pending -> next cycle state=BOOT, req=0, valid=0, then addr=RESET_PC.

Source files
------------

// File: rtl/if_stage_pkg.sv
// Shared CPU definitions for the fetch stage: word width, reset/exception
// vectors and the fetch FSM state encoding.
package if_stage_pkg;

  localparam int XLEN = 32;

  typedef logic [XLEN-1:0] word_t;

  localparam word_t CPU_RESET_PC = 32'h0000_0000;
  localparam word_t CPU_EXC_PC   = 32'h0000_0180;

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_FETCH = 2'd1,
    S_KILL  = 2'd2,
    S_HELD  = 2'd3
  } if_state_e;

  function automatic word_t pc_plus4(input word_t pc);
    return pc + word_t'(4);
  endfunction

endpackage

// File: rtl/if_stage_if_id_reg.sv
// IF/ID pipeline register: clr zeroes everything, flush drops only the
// valid bit, en captures a freshly fetched instruction.
module if_id_reg
  import if_stage_pkg::*;
(
  input  logic  clk,
  input  logic  clr,
  input  logic  en,
  input  logic  flush,
  input  word_t pc_d,
  input  word_t pc4_d,
  input  word_t instr_d,
  output logic  valid_q,
  output word_t pc_q,
  output word_t pc4_q,
  output word_t instr_q
);

  always_ff @(posedge clk) begin
    if (clr) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      pc4_q   <= '0;
      instr_q <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (en) begin
      valid_q <= 1'b1;
      pc_q    <= pc_d;
      pc4_q   <= pc4_d;
      instr_q <= instr_d;
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: PC sequencing, redirect handling, one-entry
// hold buffer for words returned while ID is stalled.
module if_stage
  import if_stage_pkg::*;
#(
  parameter word_t RESET_PC = CPU_RESET_PC,
  parameter word_t EXC_PC   = CPU_EXC_PC
) (
  input  logic  clk,
  input  logic  clr,
  input  logic  stall,
  input  logic  br_taken,
  input  word_t br_target,
  input  logic  exc_redirect,
  input  word_t exc_vector,
  output logic  imem_req,
  output word_t imem_addr,
  input  logic  imem_ready,
  input  word_t imem_rdata,
  output logic  if_id_valid,
  output word_t if_id_pc,
  output word_t if_id_pc4,
  output word_t if_id_instr
);

  // Both vectors are word addresses; catch a misaligned override at elaboration.
  if ((RESET_PC[1:0] != 2'b00) || (EXC_PC[1:0] != 2'b00)) begin : g_bad_vector
    $error("if_stage: RESET_PC and EXC_PC must be word aligned");
  end

  if_state_e state, state_n;
  word_t     pc, pc_n;
  word_t     pend_pc, pend_pc_n;
  logic      hold_valid, hold_valid_n;
  word_t     hold_pc, hold_pc_n;
  word_t     hold_instr, hold_instr_n;

  logic      redirect;
  word_t     target;
  logic      ifid_en;
  logic      ifid_flush;
  word_t     ifid_pc_d;
  word_t     ifid_instr_d;

  assign redirect  = exc_redirect | br_taken;
  assign target    = exc_redirect ? exc_vector : br_target;
  assign imem_addr = pc;

  always_ff @(posedge clk) begin
    if (clr) begin
      state      <= S_BOOT;
      pc         <= RESET_PC;
      pend_pc    <= '0;
      hold_valid <= 1'b0;
      hold_pc    <= '0;
      hold_instr <= '0;
    end else begin
      state      <= state_n;
      pc         <= pc_n;
      pend_pc    <= pend_pc_n;
      hold_valid <= hold_valid_n;
      hold_pc    <= hold_pc_n;
      hold_instr <= hold_instr_n;
    end
  end

  // The address stays at pc through FETCH and KILL, so an outstanding
  // request never changes until the memory answers it.
  always_comb begin
    state_n      = state;
    pc_n         = pc;
    pend_pc_n    = pend_pc;
    hold_valid_n = hold_valid;
    hold_pc_n    = hold_pc;
    hold_instr_n = hold_instr;
    imem_req     = 1'b0;
    ifid_en      = 1'b0;
    ifid_flush   = 1'b0;
    ifid_pc_d    = pc;
    ifid_instr_d = imem_rdata;

    case (state)
      S_BOOT: begin
        state_n    = S_FETCH;
        pc_n       = redirect ? target : RESET_PC;
        ifid_flush = redirect | ~stall;
      end

      S_FETCH: begin
        imem_req = 1'b1;
        if (redirect) begin
          ifid_flush = 1'b1;
          if (imem_ready) begin
            pc_n = target;
          end else begin
            pend_pc_n = target;
            state_n   = S_KILL;
          end
        end else if (imem_ready) begin
          if (stall) begin
            hold_valid_n = 1'b1;
            hold_pc_n    = pc;
            hold_instr_n = imem_rdata;
            state_n      = S_HELD;
          end else begin
            ifid_en = 1'b1;
            pc_n    = pc_plus4(pc);
          end
        end else if (!stall) begin
          ifid_flush = 1'b1;
        end
      end

      S_KILL: begin
        imem_req   = 1'b1;
        ifid_flush = redirect | ~stall;
        if (redirect) begin
          pend_pc_n = target;
        end
        // A redirect arriving with the discarded word still wins over pend_pc.
        if (imem_ready) begin
          pc_n    = redirect ? target : pend_pc;
          state_n = S_FETCH;
        end
      end

      S_HELD: begin
        ifid_pc_d    = hold_pc;
        ifid_instr_d = hold_instr;
        if (redirect) begin
          ifid_flush   = 1'b1;
          hold_valid_n = 1'b0;
          pc_n         = target;
          state_n      = S_FETCH;
        end else if (!stall && hold_valid) begin
          ifid_en      = 1'b1;
          hold_valid_n = 1'b0;
          pc_n         = pc_plus4(pc);
          state_n      = S_FETCH;
        end
      end

      default: begin
        state_n = S_BOOT;
      end
    endcase

    if (redirect) begin
      hold_valid_n = 1'b0;
    end
  end

  if_id_reg u_if_id_reg (
    .clk     (clk),
    .clr     (clr),
    .en      (ifid_en),
    .flush   (ifid_flush),
    .pc_d    (ifid_pc_d),
    .pc4_d   (pc_plus4(ifid_pc_d)),
    .instr_d (ifid_instr_d),
    .valid_q (if_id_valid),
    .pc_q    (if_id_pc),
    .pc4_q   (if_id_pc4),
    .instr_q (if_id_instr)
  );

endmodule

// File: tb/tb_if_stage.sv
// Directed table-driven bench for if_stage: each row drives one cycle of
// inputs and states the outputs expected before that cycle's rising edge.
module tb_if_stage;
  import if_stage_pkg::*;

  logic  clk = 1'b0;
  logic  clr, stall, br_taken, exc_redirect, imem_ready;
  word_t br_target, exc_vector;
  logic  imem_req, if_id_valid;
  word_t imem_addr, imem_rdata, if_id_pc, if_id_pc4, if_id_instr;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  function automatic word_t mem_word(input word_t a);
    return {a[15:0], ~a[15:0]};
  endfunction

  // Memory model: data is only meaningful while ready is high.
  assign imem_rdata = imem_ready ? mem_word(imem_addr) : 32'hDEAD_BEEF;

  if_stage dut (
    .clk          (clk),
    .clr          (clr),
    .stall        (stall),
    .br_taken     (br_taken),
    .br_target    (br_target),
    .exc_redirect (exc_redirect),
    .exc_vector   (exc_vector),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ready   (imem_ready),
    .imem_rdata   (imem_rdata),
    .if_id_valid  (if_id_valid),
    .if_id_pc     (if_id_pc),
    .if_id_pc4    (if_id_pc4),
    .if_id_instr  (if_id_instr)
  );

  typedef struct {
    logic  clr, stall, ready, br;
    word_t btgt;
    logic  exc;
    word_t evec;
    logic  exp_req;
    word_t exp_addr;
    logic  exp_valid;
    logic  chk_ifid;
    word_t exp_pc, exp_pc4, exp_instr;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic c, input logic s, input logic r,
                              input logic b, input word_t bt,
                              input logic e, input word_t ev,
                              input logic ereq, input word_t eaddr,
                              input logic evalid, input logic chk, input word_t epc);
    vec_t v;
    v.clr = c; v.stall = s; v.ready = r; v.br = b; v.btgt = bt;
    v.exc = e; v.evec = ev;
    v.exp_req = ereq; v.exp_addr = eaddr; v.exp_valid = evalid;
    v.chk_ifid = chk; v.exp_pc = epc;
    v.exp_pc4   = evalid ? epc + 32'd4 : 32'd0;
    v.exp_instr = evalid ? mem_word(epc) : 32'd0;
    return v;
  endfunction

  task automatic checkOutput(input string name, input word_t actual, input word_t expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    clr          = v.clr;
    stall        = v.stall;
    imem_ready   = v.ready;
    br_taken     = v.br;
    br_target    = v.btgt;
    exc_redirect = v.exc;
    exc_vector   = v.evec;
    #1;
  endtask

  initial begin
    clr = 1'b1; stall = 1'b0; imem_ready = 1'b0;
    br_taken = 1'b0; br_target = '0; exc_redirect = 1'b0; exc_vector = '0;

    //           clr stl rdy br  btgt          exc evec          req addr          vld chk pc
    vecs.push_back(mk(0, 0, 1, 0, 32'h0,        0, 32'h0,         0, 32'h0,        0, 1, 32'h0));
    vecs.push_back(mk(0, 0, 1, 0, 32'h0,        0, 32'h0,         1, 32'h0,        0, 0, 32'h0));
    vecs.push_back(mk(0, 0, 1, 0, 32'h0,        0, 32'h0,         1, 32'h4,        1, 1, 32'h0));
    vecs.push_back(mk(0, 1, 1, 0, 32'h0,        0, 32'h0,         1, 32'h8,        1, 1, 32'h4));
    vecs.push_back(mk(0, 1, 0, 0, 32'h0,        0, 32'h0,         0, 32'h8,        1, 1, 32'h4));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,        0, 32'h0,         0, 32'h8,        1, 1, 32'h4));
    vecs.push_back(mk(0, 0, 1, 0, 32'h0,        0, 32'h0,         1, 32'hC,        1, 1, 32'h8));
    vecs.push_back(mk(0, 0, 0, 1, 32'h100,      0, 32'h0,         1, 32'h10,       1, 1, 32'hC));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,        0, 32'h0,         1, 32'h10,       0, 0, 32'h0));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,        0, 32'h0,         1, 32'h10,       0, 0, 32'h0));
    vecs.push_back(mk(0, 0, 1, 0, 32'h0,        0, 32'h0,         1, 32'h10,       0, 0, 32'h0));
    vecs.push_back(mk(0, 0, 1, 1, 32'h200,      1, 32'h180,       1, 32'h100,      0, 0, 32'h0));
    vecs.push_back(mk(0, 0, 1, 0, 32'h0,        0, 32'h0,         1, 32'h180,      0, 0, 32'h0));
    vecs.push_back(mk(0, 0, 1, 1, 32'hFFFF_FFFC, 0, 32'h0,        1, 32'h184,      1, 1, 32'h180));
    vecs.push_back(mk(0, 0, 1, 0, 32'h0,        0, 32'h0,         1, 32'hFFFF_FFFC, 0, 0, 32'h0));
    vecs.push_back(mk(0, 0, 1, 0, 32'h0,        0, 32'h0,         1, 32'h0,        1, 1, 32'hFFFF_FFFC));
    vecs.push_back(mk(0, 1, 1, 0, 32'h0,        0, 32'h0,         1, 32'h4,        1, 1, 32'h0));
    vecs.push_back(mk(0, 1, 0, 1, 32'h40,       0, 32'h0,         0, 32'h4,        1, 1, 32'h0));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,        0, 32'h0,         1, 32'h40,       0, 0, 32'h0));
    vecs.push_back(mk(0, 0, 0, 1, 32'h80,       0, 32'h0,         1, 32'h40,       0, 0, 32'h0));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,        1, 32'h180,       1, 32'h40,       0, 0, 32'h0));
    vecs.push_back(mk(0, 0, 1, 0, 32'h0,        0, 32'h0,         1, 32'h40,       0, 0, 32'h0));
    vecs.push_back(mk(0, 0, 1, 0, 32'h0,        0, 32'h0,         1, 32'h180,      0, 0, 32'h0));
    vecs.push_back(mk(1, 0, 0, 0, 32'h0,        0, 32'h0,         1, 32'h184,      1, 1, 32'h180));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,        0, 32'h0,         0, 32'h0,        0, 1, 32'h0));
    vecs.push_back(mk(0, 0, 1, 0, 32'h0,        0, 32'h0,         1, 32'h0,        0, 0, 32'h0));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,        0, 32'h0,         1, 32'h4,        1, 1, 32'h0));

    // Reset held for two edges; outputs must already be idle after the first.
    @(posedge clk);
    @(negedge clk);
    checkOutput("reset_req", word_t'(imem_req), 32'd0);
    checkOutput("reset_valid", word_t'(if_id_valid), 32'd0);
    @(posedge clk);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("row%0d_req", i), word_t'(imem_req), word_t'(vecs[i].exp_req));
      checkOutput($sformatf("row%0d_addr", i), imem_addr, vecs[i].exp_addr);
      checkOutput($sformatf("row%0d_valid", i), word_t'(if_id_valid), word_t'(vecs[i].exp_valid));
      if (vecs[i].chk_ifid) begin
        checkOutput($sformatf("row%0d_ifpc", i), if_id_pc, vecs[i].exp_pc);
        checkOutput($sformatf("row%0d_ifpc4", i), if_id_pc4, vecs[i].exp_pc4);
        checkOutput($sformatf("row%0d_instr", i), if_id_instr, vecs[i].exp_instr);
      end
    end

    // Bounded wait: with memory ready the word at 0x4 must reach IF/ID.
    begin
      bit seen = 1'b0;
      vec_t go = mk(0, 0, 1, 0, 32'h0, 0, 32'h0, 1, 32'h4, 1, 0, 32'h4);
      for (int n = 0; n < 8 && !seen; n++) begin
        applyStimulus(go);
        if (if_id_valid && if_id_pc == 32'h4) seen = 1'b1;
      end
      checkOutput("wait_fetch4", word_t'(seen), 32'd1);
      checkOutput("wait_instr4", if_id_instr, mem_word(32'h4));
      checkOutput("wait_pc4", if_id_pc4, 32'h8);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
